// File: rtl/byte_cmd_loader_pkg.sv
// Shared definitions for the byte command loader: command codes, FSM state
// encoding and the big-endian lane to byte-enable decode.
package byte_cmd_loader_pkg;

   localparam logic [7:0] CMD_NOP   = 8'd0;
   localparam logic [7:0] CMD_READ  = 8'd1;
   localparam logic [7:0] CMD_WRITE = 8'd2;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WRITE     = 3'd1,
      ST_READ_WAIT = 3'd2,
      ST_CAPTURE   = 3'd3,
      ST_DONE      = 3'd4,
      ST_HOLD      = 3'd5,
      ST_RUN       = 3'd6
   } state_t;

   // Byte lane 0 sits in bits 31:24, so lane n enables mem_be bit 3-n.
   function automatic logic [3:0] lane_be(input logic [1:0] lane);
      logic [3:0] be;
      case (lane)
         2'd0:    be = 4'b1000;
         2'd1:    be = 4'b0100;
         2'd2:    be = 4'b0010;
         2'd3:    be = 4'b0001;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/byte_cmd_loader.sv
// Byte-wide host command loader in front of the 32-bit core memory port.
// Each accepted byte command becomes a single byte-enabled word access; while
// start_signal is high the memory is handed to the CPU via cpu_run.
// All outputs are registered: they are computed from the next state and the
// next latched command, so they line up with the state they describe.
module byte_cmd_loader
   import byte_cmd_loader_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        cmd,
   input  logic              cmd_valid,
   input  logic [ADDR_W-1:0] address,
   input  logic [7:0]        data_in,
   input  logic              start_signal,
   output logic              cmd_done,
   output logic [7:0]        data_out,
   output logic              busy,
   output logic              cpu_run,
   output logic              mem_en,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   // Last count value of the read-latency wait (READ_LAT is 1..4).
   localparam logic [1:0] LAT_LAST = 2'(READ_LAT - 1);

   state_t              state_r;
   state_t              state_s;
   logic [7:0]          cmd_r;
   logic [7:0]          cmd_s;
   logic [ADDR_W-1:0]   addr_r;
   logic [ADDR_W-1:0]   addr_s;
   logic [7:0]          wdat_r;
   logic [7:0]          wdat_s;
   logic [1:0]          lat_cnt_r;
   logic [1:0]          lat_cnt_s;

   logic                cmd_done_r;
   logic                cmd_done_s;
   logic [7:0]          data_out_r;
   logic                busy_r;
   logic                busy_s;
   logic                cpu_run_r;
   logic                cpu_run_s;
   logic                mem_en_r;
   logic                mem_en_s;
   logic                mem_we_r;
   logic                mem_we_s;
   logic [3:0]          mem_be_r;
   logic [3:0]          mem_be_s;
   logic [ADDR_W-3:0]   mem_addr_r;
   logic [31:0]         mem_wdata_r;
   logic [7:0]          rd_byte_s;

   // Next-state decode and command latching.
   always_comb begin
      state_s   = state_r;
      cmd_s     = cmd_r;
      addr_s    = addr_r;
      wdat_s    = wdat_r;
      lat_cnt_s = lat_cnt_r;
      case (state_r)
         ST_IDLE: begin
            // A command wins over start_signal when both arrive together.
            if (cmd_valid && !cpu_run_r) begin
               cmd_s     = cmd;
               addr_s    = address;
               wdat_s    = data_in;
               lat_cnt_s = 2'd0;
               if (cmd_s == CMD_WRITE) begin
                  state_s = ST_WRITE;
               end else if (cmd_s == CMD_READ) begin
                  state_s = ST_READ_WAIT;
               end else begin
                  state_s = ST_DONE;
               end
            end else if (start_signal) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WRITE: begin
            state_s = ST_DONE;
         end
         ST_READ_WAIT: begin
            if (lat_cnt_r == LAT_LAST) begin
               lat_cnt_s = 2'd0;
               state_s   = ST_CAPTURE;
            end else begin
               lat_cnt_s = lat_cnt_r + 2'd1;
               state_s   = ST_READ_WAIT;
            end
         end
         ST_CAPTURE: begin
            state_s = ST_DONE;
         end
         ST_DONE: begin
            state_s = ST_HOLD;
         end
         ST_HOLD: begin
            // A held cmd_valid must be released before another command runs.
            if (!cmd_valid) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_HOLD;
            end
         end
         ST_RUN: begin
            if (!start_signal) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RUN;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Next values of the registered outputs, derived from the next state.
   always_comb begin
      mem_en_s   = 1'b0;
      mem_we_s   = 1'b0;
      mem_be_s   = 4'b0000;
      cmd_done_s = (state_s == ST_DONE);
      busy_s     = (state_s != ST_IDLE);
      cpu_run_s  = (state_s == ST_RUN);
      if (state_s == ST_WRITE) begin
         mem_en_s = 1'b1;
         mem_we_s = 1'b1;
         mem_be_s = lane_be(addr_s[1:0]);
      end else if ((state_s == ST_READ_WAIT) && (state_r != ST_READ_WAIT)) begin
         // Read strobe only on the first wait cycle.
         mem_en_s = 1'b1;
         mem_we_s = 1'b0;
         mem_be_s = 4'b1111;
      end else begin
         mem_en_s = 1'b0;
         mem_we_s = 1'b0;
         mem_be_s = 4'b0000;
      end
   end

   // Big-endian byte lane select from the returned read word.
   always_comb begin
      rd_byte_s = 8'h00;
      case (addr_r[1:0])
         2'd0:    rd_byte_s = mem_rdata[31:24];
         2'd1:    rd_byte_s = mem_rdata[23:16];
         2'd2:    rd_byte_s = mem_rdata[15:8];
         2'd3:    rd_byte_s = mem_rdata[7:0];
         default: rd_byte_s = 8'h00;
      endcase
   end

   // State, latched command and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cmd_r       <= 8'h00;
         addr_r      <= '0;
         wdat_r      <= 8'h00;
         lat_cnt_r   <= 2'd0;
         cmd_done_r  <= 1'b0;
         data_out_r  <= 8'h00;
         busy_r      <= 1'b0;
         cpu_run_r   <= 1'b0;
         mem_en_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_be_r    <= 4'b0000;
         mem_addr_r  <= '0;
         mem_wdata_r <= 32'h0000_0000;
      end else begin
         state_r     <= state_s;
         cmd_r       <= cmd_s;
         addr_r      <= addr_s;
         wdat_r      <= wdat_s;
         lat_cnt_r   <= lat_cnt_s;
         cmd_done_r  <= cmd_done_s;
         busy_r      <= busy_s;
         cpu_run_r   <= cpu_run_s;
         mem_en_r    <= mem_en_s;
         mem_we_r    <= mem_we_s;
         mem_be_r    <= mem_be_s;
         mem_addr_r  <= addr_s[ADDR_W-1:2];
         mem_wdata_r <= {4{wdat_s}};
         if (state_r == ST_CAPTURE) begin
            data_out_r <= rd_byte_s;
         end else begin
            data_out_r <= data_out_r;
         end
      end
   end

   assign cmd_done  = cmd_done_r;
   assign data_out  = data_out_r;
   assign busy      = busy_r;
   assign cpu_run   = cpu_run_r;
   assign mem_en    = mem_en_r;
   assign mem_we    = mem_we_r;
   assign mem_be    = mem_be_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_byte_cmd_loader.sv
// Directed self-checking bench for byte_cmd_loader with a simple
// one-cycle-latency word memory model.
module tb_byte_cmd_loader;
   import byte_cmd_loader_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  cmd;
   logic        cmd_valid;
   logic [7:0]  address;
   logic [7:0]  data_in;
   logic        start_signal;
   logic        cmd_done;
   logic [7:0]  data_out;
   logic        busy;
   logic        cpu_run;
   logic        mem_en;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'h0000_0000;

   logic [31:0] mem_q [0:63];
   int          en_cnt = 0;
   int          we_cnt = 0;
   int          done_cnt = 0;
   int          tests = 0;
   int          fails = 0;
   int          en0, we0, done0;

   byte_cmd_loader #(.ADDR_W(8), .READ_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_valid(cmd_valid),
      .address(address), .data_in(data_in), .start_signal(start_signal),
      .cmd_done(cmd_done), .data_out(data_out), .busy(busy), .cpu_run(cpu_run),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: byte-enabled write, read data one cycle after mem_en.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_be[b]) mem_q[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
         end else begin
            mem_rdata <= mem_q[mem_addr];
         end
      end
   end

   // Pulse counters for exactly-once checks.
   always @(posedge clk) begin
      if (mem_en)   en_cnt   <= en_cnt + 1;
      if (mem_we)   we_cnt   <= we_cnt + 1;
      if (cmd_done) done_cnt <= done_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      en0 = en_cnt; we0 = we_cnt; done0 = done_cnt;
   endtask

   // Write with cmd_valid held 5 cycles; inputs scrambled after accept.
   task automatic do_write(input logic [7:0] a, input logic [7:0] d,
                           input logic [3:0] be_exp, input logic [31:0] wd_exp);
      snap();
      cmd = CMD_WRITE; address = a; data_in = d; cmd_valid = 1'b1;
      tick();
      address = 8'hFC; data_in = 8'hEE;
      chk("wr_en", {31'd0, mem_en}, 32'd1);
      chk("wr_we", {31'd0, mem_we}, 32'd1);
      chk("wr_be", {28'd0, mem_be}, {28'd0, be_exp});
      chk("wr_addr", {26'd0, mem_addr}, 32'd0);
      chk("wr_wdata", mem_wdata, wd_exp);
      tick();
      chk("wr_done", {31'd0, cmd_done}, 32'd1);
      chk("wr_we_off", {31'd0, mem_we}, 32'd0);
      tick(); tick(); tick();
      cmd_valid = 1'b0;
      tick(); tick();
      chk("wr_we_once", we_cnt - we0, 32'd1);
      chk("wr_done_once", done_cnt - done0, 32'd1);
      chk("wr_idle", {31'd0, busy}, 32'd0);
   endtask

   // Read: mem_en cycle 1, cmd_done and data_out cycle 3.
   task automatic do_read(input logic [7:0] a, input logic [7:0] exp);
      snap();
      cmd = CMD_READ; address = a; cmd_valid = 1'b1;
      tick();
      chk("rd_en", {31'd0, mem_en}, 32'd1);
      chk("rd_we", {31'd0, mem_we}, 32'd0);
      chk("rd_be", {28'd0, mem_be}, 32'hF);
      tick();
      chk("rd_en_off", {31'd0, mem_en}, 32'd0);
      chk("rd_done_early", {31'd0, cmd_done}, 32'd0);
      tick();
      chk("rd_done", {31'd0, cmd_done}, 32'd1);
      chk("rd_data", {24'd0, data_out}, {24'd0, exp});
      cmd_valid = 1'b0;
      tick(); tick();
      chk("rd_en_once", en_cnt - en0, 32'd1);
      chk("rd_data_hold", {24'd0, data_out}, {24'd0, exp});
   endtask

   // Unsupported or NOP: done pulse on cycle 1, no access, data_out kept.
   task automatic do_nop(input logic [7:0] c, input logic [7:0] dout_exp);
      snap();
      cmd = c; address = 8'h02; cmd_valid = 1'b1;
      tick();
      chk("nop_done", {31'd0, cmd_done}, 32'd1);
      tick();
      chk("nop_done_off", {31'd0, cmd_done}, 32'd0);
      cmd_valid = 1'b0;
      tick(); tick();
      chk("nop_no_access", en_cnt - en0, 32'd0);
      chk("nop_done_once", done_cnt - done0, 32'd1);
      chk("nop_dout", {24'd0, data_out}, {24'd0, dout_exp});
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem_q[i] = 32'h0000_0000;
      rst_n = 1'b0; cmd = 8'h00; cmd_valid = 1'b0; address = 8'h00;
      data_in = 8'h00; start_signal = 1'b0;
      tick(); tick();
      chk("rst_done", {31'd0, cmd_done}, 32'd0);
      chk("rst_outs", {data_out, busy, cpu_run, mem_en, mem_we, mem_be, 14'd0}, 32'd0);
      chk("rst_addr_wd", {26'd0, mem_addr} | mem_wdata, 32'd0);
      rst_n = 1'b1;
      tick();

      do_write(8'h00, 8'h00, 4'b1000, 32'h0000_0000);
      do_write(8'h01, 8'h30, 4'b0100, 32'h3030_3030);
      do_write(8'h02, 8'h01, 4'b0010, 32'h0101_0101);
      do_write(8'h03, 8'h13, 4'b0001, 32'h1313_1313);
      chk("mem_word0", mem_q[0], 32'h0030_0113);

      do_read(8'h01, 8'h30);
      do_read(8'h03, 8'h13);

      do_nop(8'd5, 8'h13);
      do_nop(CMD_NOP, 8'h13);

      // CPU ownership: commands ignored while running.
      snap();
      start_signal = 1'b1;
      tick();
      chk("run_cpu", {31'd0, cpu_run}, 32'd1);
      chk("run_busy", {31'd0, busy}, 32'd1);
      cmd = CMD_WRITE; address = 8'h02; data_in = 8'hAA; cmd_valid = 1'b1;
      tick(); tick(); tick();
      chk("run_no_access", en_cnt - en0, 32'd0);
      chk("run_no_done", done_cnt - done0, 32'd0);
      start_signal = 1'b0;
      tick();
      chk("run_release", {31'd0, cpu_run}, 32'd0);
      tick();
      chk("pend_we", {31'd0, mem_we}, 32'd1);
      chk("pend_be", {28'd0, mem_be}, 32'h2);
      chk("pend_wd", mem_wdata, 32'hAAAA_AAAA);
      tick();
      chk("pend_done", {31'd0, cmd_done}, 32'd1);
      cmd_valid = 1'b0;
      tick(); tick();
      chk("mem_word0_b", mem_q[0], 32'h0030_AA13);

      // start_signal rises one cycle after a read is accepted.
      cmd = CMD_READ; address = 8'h01; cmd_valid = 1'b1;
      tick();
      start_signal = 1'b1;
      tick(); tick();
      chk("mid_done", {31'd0, cmd_done}, 32'd1);
      chk("mid_data", {24'd0, data_out}, 32'h30);
      chk("mid_cpu_wait", {31'd0, cpu_run}, 32'd0);
      cmd_valid = 1'b0;
      tick(); tick();
      chk("mid_idle", {31'd0, cpu_run}, 32'd0);
      tick();
      chk("mid_run", {31'd0, cpu_run}, 32'd1);
      start_signal = 1'b0;
      tick();
      chk("mid_release", {31'd0, cpu_run}, 32'd0);

      // Reset during READ_WAIT aborts without cmd_done.
      snap();
      cmd = CMD_READ; address = 8'h03; cmd_valid = 1'b1;
      tick();
      chk("rr_en", {31'd0, mem_en}, 32'd1);
      rst_n = 1'b0;
      tick();
      chk("rr_outs", {data_out, busy, cpu_run, mem_en, mem_we, mem_be, cmd_done, 13'd0}, 32'd0);
      rst_n = 1'b1; cmd_valid = 1'b0;
      tick(); tick(); tick();
      chk("rr_no_done", done_cnt - done0, 32'd0);
      chk("rr_idle", {31'd0, busy}, 32'd0);
      do_write(8'h00, 8'h55, 4'b1000, 32'h5555_5555);
      chk("mem_word0_c", mem_q[0], 32'h5530_AA13);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
